// File: rtl/spaceinputs_sched_if.sv
// Source-side bundle for the input scheduler: event header strobe,
// stub word stream and the back-pressure flag.
interface spaceinputs_sched_if #(
    parameter int DATA_W = 36,
    parameter int BX_W   = 3,
    parameter int NUM_W  = 6
);
    logic              eventin;
    logic [BX_W-1:0]   bxin;
    logic [NUM_W-1:0]  numin;
    logic [DATA_W-1:0] datain;
    logic              datain_valid;
    logic              in_ready;

    modport master (
        output eventin, bxin, numin,
        output datain, datain_valid,
        input  in_ready
    );

    modport slave (
        input  eventin, bxin, numin,
        input  datain, datain_valid,
        output in_ready
    );
endinterface

// File: rtl/spaceinputs_sched.sv
// Paces buffered event headers and stub words into the pipeline,
// one event per BC0-aligned slot, words SPACING clocks apart.
module spaceinputs_sched #(
    parameter int DATA_W     = 36,
    parameter int BX_W       = 3,
    parameter int NUM_W      = 6,
    parameter int FIFO_AW    = 6,
    parameter int HDR_AW     = 2,
    parameter int EVT_PERIOD = 108,
    parameter int SPACING    = 2,
    parameter int MAXW       = 53
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              BC0,
    spaceinputs_sched_if.slave src,
    output logic [DATA_W-1:0] dataout,
    output logic              dataout_valid,
    output logic [BX_W-1:0]   bxout,
    output logic              event_start,
    output logic              late,
    output logic              truncated,
    output logic              overflow
);
    localparam int IW = $clog2(MAXW + 1);
    localparam int CW = $clog2(EVT_PERIOD);
    localparam int GW = (SPACING > 2) ? $clog2(SPACING) : 1;
    localparam int HW = BX_W + NUM_W;

    localparam logic [IW-1:0]    MAXW_I = IW'(MAXW);
    localparam logic [NUM_W-1:0] MAXW_N = NUM_W'(MAXW);
    localparam logic [NUM_W-1:0] ONE_N  = NUM_W'(1);
    localparam logic [CW-1:0]    LAST   = CW'(EVT_PERIOD - 1);
    localparam logic [GW-1:0]    GLOAD  =
        GW'((SPACING > 1) ? SPACING - 2 : 0);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    logic [HW-1:0]       hmem [2**HDR_AW];
    logic [HDR_AW:0]     hwp, hrp;
    logic [DATA_W-1:0]   dmem [2**FIFO_AW];
    logic [FIFO_AW:0]    dwp, drp;
    logic                hdr_full, hdr_empty;
    logic                data_full, data_empty;

    logic [IW-1:0]       idx, idx_eff;
    logic                ev_acc, dv_acc, word_ok;
    logic                hdr_pop, data_pop, late_d;
    logic                armed, slot_start;
    logic [CW-1:0]       cnt;
    logic [NUM_W-1:0]    rem, num_clip;
    logic [GW-1:0]       gcnt;
    logic [HW-1:0]       hdr_rd;
    logic [BX_W-1:0]     hdr_bx;
    logic [NUM_W-1:0]    hdr_cnt;
    state_t              state, state_d;

    // Extra pointer MSB distinguishes full from empty.
    assign hdr_empty  = (hwp == hrp);
    assign hdr_full   = (hwp[HDR_AW] != hrp[HDR_AW]) &&
                        (hwp[HDR_AW-1:0] == hrp[HDR_AW-1:0]);
    assign data_empty = (dwp == drp);
    assign data_full  = (dwp[FIFO_AW] != drp[FIFO_AW]) &&
                        (dwp[FIFO_AW-1:0] == drp[FIFO_AW-1:0]);

    assign src.in_ready = !hdr_full && !data_full;

    assign ev_acc   = src.eventin && src.in_ready;
    assign dv_acc   = src.datain_valid && src.in_ready;
    assign idx_eff  = ev_acc ? '0 : idx;
    assign word_ok  = dv_acc && (idx_eff < MAXW_I);
    assign num_clip = (src.numin > MAXW_N) ? MAXW_N : src.numin;

    assign hdr_rd  = hmem[hrp[HDR_AW-1:0]];
    assign hdr_bx  = hdr_rd[HW-1 -: BX_W];
    assign hdr_cnt = hdr_rd[NUM_W-1:0];

    assign slot_start = BC0 || (armed && (cnt == LAST));

    always_ff @(posedge clk) begin
        if (ev_acc)
            hmem[hwp[HDR_AW-1:0]] <= {src.bxin, num_clip};
        if (word_ok)
            dmem[dwp[FIFO_AW-1:0]] <= src.datain;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwp       <= '0;
            hrp       <= '0;
            dwp       <= '0;
            drp       <= '0;
            idx       <= '0;
            truncated <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (ev_acc)   hwp <= hwp + 1'b1;
            if (hdr_pop)  hrp <= hrp + 1'b1;
            if (word_ok)  dwp <= dwp + 1'b1;
            if (data_pop) drp <= drp + 1'b1;
            if (word_ok)
                idx <= idx_eff + 1'b1;
            else if (ev_acc)
                idx <= '0;
            truncated <= dv_acc && !word_ok;
            if ((src.eventin || src.datain_valid) && !src.in_ready)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (BC0) begin
            armed <= 1'b1;
            cnt   <= '0;
        end else if (armed) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (slot_start && !hdr_empty && hdr_cnt != '0)
                    state_d = EMIT;
            end
            EMIT: begin
                if (!data_empty) begin
                    if (rem == ONE_N)     state_d = IDLE;
                    else if (SPACING > 1) state_d = GAP;
                end
            end
            GAP: begin
                if (gcnt == '0) state_d = EMIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hdr_pop  = 1'b0;
        data_pop = 1'b0;
        late_d   = 1'b0;
        unique case (1'b1)
            (state == IDLE): hdr_pop  = slot_start && !hdr_empty;
            (state == EMIT): data_pop = !data_empty;
            default: ;
        endcase
        if (state != IDLE) late_d = slot_start;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem           <= '0;
            gcnt          <= '0;
            bxout         <= '0;
            dataout       <= '0;
            dataout_valid <= 1'b0;
            event_start   <= 1'b0;
            late          <= 1'b0;
        end else begin
            event_start   <= hdr_pop;
            late          <= late_d;
            dataout_valid <= data_pop;
            if (hdr_pop) begin
                bxout <= hdr_bx;
                rem   <= hdr_cnt;
            end else if (data_pop) begin
                rem <= rem - 1'b1;
            end
            if (data_pop)
                dataout <= dmem[drp[FIFO_AW-1:0]];
            if (data_pop)
                gcnt <= GLOAD;
            else if (state == GAP && gcnt != '0)
                gcnt <= gcnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_spaceinputs_sched.sv
// Directed bench for the event scheduler: slot pacing, truncation,
// stalls, back-pressure and BC0 realignment.
module tb_spaceinputs_sched;
    localparam int DATA_W = 36;
    localparam int BX_W   = 3;
    localparam int NUM_W  = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic BC0 = 1'b0;
    logic [DATA_W-1:0] dataout;
    logic              dataout_valid;
    logic [BX_W-1:0]   bxout;
    logic              event_start, late, truncated, overflow;

    int checks = 0;
    int fails  = 0;

    spaceinputs_sched_if #(
        .DATA_W(DATA_W), .BX_W(BX_W), .NUM_W(NUM_W)
    ) bus ();

    spaceinputs_sched dut (
        .clk(clk),
        .reset(reset),
        .BC0(BC0),
        .src(bus),
        .dataout(dataout),
        .dataout_valid(dataout_valid),
        .bxout(bxout),
        .event_start(event_start),
        .late(late),
        .truncated(truncated),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        BC0 = 1'b0;
        bus.eventin = 1'b0;
        bus.datain_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push_event(input logic [BX_W-1:0] bx,
                              input logic [NUM_W-1:0] n);
        bus.bxin = bx;
        bus.numin = n;
        bus.eventin = 1'b1;
        tick();
        bus.eventin = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        bus.datain = w;
        bus.datain_valid = 1'b1;
        tick();
        bus.datain_valid = 1'b0;
    endtask

    task automatic pulse_bc0();
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
    endtask

    task automatic test_reset();
        logic [DATA_W+BX_W+4:0] outs;
        reset = 1'b0;
        tick();
        outs = {dataout_valid, event_start, late, truncated,
                overflow, bxout, dataout};
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outs: got %0h want 0", outs);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) push_event(3'(i), 6'd1);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hdr_full_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_pre: got %b want 0", overflow);
        end
        push_event(3'd4, 6'd1);
        checks++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_hdr: got %b want 1", overflow);
        end
        repeat (5) tick();
        checks++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        do_reset();
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_cleared: got %b want 0", overflow);
        end
        for (int e = 0; e < 2; e++) begin
            push_event(3'(e + 1), 6'd32);
            for (int i = 0; i < 32; i++)
                push_word(DATA_W'(e * 32 + i + 16'h200));
        end
        checks++;
        if (bus.in_ready !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL data_full: got rdy=%b ovf=%b want 0 0",
                     bus.in_ready, overflow);
        end
        push_word(36'hDEAD);
        checks++;
        if (overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_data: got %b want 1", overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W+BX_W+4:0] outs;
        pulse_bc0();
        tick();
        checks++;
        if (dataout_valid !== 1'b1 || dataout !== 36'h200) begin
            fails++;
            $display("FAIL mid_emit: got v=%b d=%0h want 1 200",
                     dataout_valid, dataout);
        end
        reset = 1'b0;
        #1;
        outs = {dataout_valid, event_start, late, truncated,
                overflow, bxout, dataout};
        checks++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL mid_reset_outs: got %0h want 0", outs);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_ready: got %b want 1",
                     bus.in_ready);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_event();
        logic [DATA_W-1:0] exp_w [3];
        int vn;
        logic ev, vv;
        exp_w[0] = 36'hA_0000_000A;
        exp_w[1] = 36'hB_0000_000B;
        exp_w[2] = 36'hC_0000_000C;
        vn = 0;
        do_reset();
        push_event(3'd5, 6'd3);
        for (int i = 0; i < 3; i++) push_word(exp_w[i]);
        pulse_bc0();
        for (int c = 1; c <= 10; c++) begin
            ev = (c == 1);
            vv = (c == 2 || c == 4 || c == 6);
            checks++;
            if (event_start !== ev) begin
                fails++;
                $display("FAIL single_es c=%0d: got %b want %b",
                         c, event_start, ev);
            end
            checks++;
            if (dataout_valid !== vv) begin
                fails++;
                $display("FAIL single_valid c=%0d: got %b want %b",
                         c, dataout_valid, vv);
            end
            if (vv) begin
                checks++;
                if (dataout !== exp_w[vn]) begin
                    fails++;
                    $display("FAIL single_data c=%0d: got %0h want %0h",
                             c, dataout, exp_w[vn]);
                end
                vn++;
            end
            if (c >= 7) begin
                checks++;
                if (dataout !== exp_w[2]) begin
                    fails++;
                    $display("FAIL single_hold c=%0d: got %0h want %0h",
                             c, dataout, exp_w[2]);
                end
            end
            checks++;
            if (bxout !== 3'd5 || late !== 1'b0) begin
                fails++;
                $display("FAIL single_bx c=%0d: got bx=%0d late=%b want 5 0",
                         c, bxout, late);
            end
            tick();
        end
    endtask

    task automatic test_three_events();
        int st [4];
        int ns, nl, nw;
        ns = 0; nl = 0; nw = 0;
        do_reset();
        for (int e = 0; e < 3; e++) begin
            push_event(3'(e + 1), 6'd2);
            push_word(DATA_W'(e * 2 + 16'h300));
            push_word(DATA_W'(e * 2 + 16'h301));
        end
        pulse_bc0();
        for (int c = 1; c <= 230; c++) begin
            if (event_start) begin
                if (ns < 4) st[ns] = c;
                ns++;
            end
            if (late) nl++;
            if (dataout_valid) nw++;
            tick();
        end
        checks++;
        if (ns !== 3) begin
            fails++;
            $display("FAIL three_count: got %0d want 3", ns);
        end else begin
            checks++;
            if (st[0] != 1 || st[1] != 109 || st[2] != 217) begin
                fails++;
                $display("FAIL three_times: got %0d %0d %0d want 1 109 217",
                         st[0], st[1], st[2]);
            end
        end
        checks++;
        if (nl != 0 || nw != 6) begin
            fails++;
            $display("FAIL three_late_words: got late=%0d words=%0d want 0 6",
                     nl, nw);
        end
    endtask

    task automatic test_truncate();
        int nt, nw, nl, ne;
        logic [DATA_W-1:0] first_w, last_w;
        nt = 0; nw = 0; nl = 0; ne = 0;
        first_w = '0; last_w = '0;
        do_reset();
        push_event(3'd3, 6'd60);
        for (int i = 0; i < 60; i++) begin
            push_word(DATA_W'(100 + i));
            if (truncated) nt++;
        end
        tick();
        if (truncated) nt++;
        checks++;
        if (nt != 7) begin
            fails++;
            $display("FAIL trunc_pulses: got %0d want 7", nt);
        end
        checks++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL trunc_ovf: got %b want 0", overflow);
        end
        pulse_bc0();
        for (int c = 1; c <= 220; c++) begin
            if (dataout_valid) begin
                if (nw == 0) first_w = dataout;
                last_w = dataout;
                nw++;
            end
            if (late) nl++;
            if (event_start) ne++;
            tick();
        end
        checks++;
        if (nw != 53 || nl != 0 || ne != 1) begin
            fails++;
            $display("FAIL trunc_emit: got w=%0d late=%0d es=%0d want 53 0 1",
                     nw, nl, ne);
        end
        checks++;
        if (first_w !== 36'd100 || last_w !== 36'd152) begin
            fails++;
            $display("FAIL trunc_data: got %0d..%0d want 100..152",
                     first_w, last_w);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] seen [8];
        int st [4];
        int ns, nw, nl, lc;
        ns = 0; nw = 0; nl = 0; lc = 0;
        do_reset();
        push_event(3'd1, 6'd4);
        push_word(36'h400);
        push_word(36'h401);
        push_event(3'd2, 6'd1);
        pulse_bc0();
        fork
            begin
                for (int c = 1; c <= 240; c++) begin
                    if (event_start) begin
                        if (ns < 4) st[ns] = c;
                        ns++;
                    end
                    if (late) begin
                        nl++;
                        lc = c;
                    end
                    if (dataout_valid) begin
                        if (nw < 8) seen[nw] = dataout;
                        nw++;
                    end
                    tick();
                end
            end
            begin
                repeat (149) tick();
                push_word(36'h402);
                push_word(36'h403);
                push_word(36'h404);
            end
        join
        checks++;
        if (nl != 1 || lc != 109) begin
            fails++;
            $display("FAIL stall_late: got n=%0d at %0d want 1 at 109",
                     nl, lc);
        end
        checks++;
        if (ns != 2) begin
            fails++;
            $display("FAIL stall_es_count: got %0d want 2", ns);
        end else begin
            checks++;
            if (st[0] != 1 || st[1] != 217) begin
                fails++;
                $display("FAIL stall_es_times: got %0d %0d want 1 217",
                         st[0], st[1]);
            end
        end
        checks++;
        if (nw != 5) begin
            fails++;
            $display("FAIL stall_words: got %0d want 5", nw);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] !== DATA_W'(16'h400 + i)) begin
                    fails++;
                    $display("FAIL stall_data[%0d]: got %0h want %0h",
                             i, seen[i], 16'h400 + i);
                end
            end
        end
        checks++;
        if (bxout !== 3'd2) begin
            fails++;
            $display("FAIL stall_bx: got %0d want 2", bxout);
        end
    endtask

    task automatic test_bc0_realign();
        int quiet;
        quiet = 0;
        do_reset();
        pulse_bc0();
        push_event(3'd6, 6'd1);
        push_word(36'h600);
        for (int k = 3; k <= 40; k++) begin
            tick();
            if (event_start) quiet++;
        end
        BC0 = 1'b1;
        tick();
        BC0 = 1'b0;
        checks++;
        if (event_start !== 1'b1 || bxout !== 3'd6) begin
            fails++;
            $display("FAIL realign_pop: got es=%b bx=%0d want 1 6",
                     event_start, bxout);
        end
        push_event(3'd7, 6'd0);
        for (int k = 43; k <= 148; k++) begin
            tick();
            if (event_start) quiet++;
        end
        checks++;
        if (quiet != 0) begin
            fails++;
            $display("FAIL realign_quiet: got %0d pops want 0", quiet);
        end
        tick();
        checks++;
        if (event_start !== 1'b1 || bxout !== 3'd7) begin
            fails++;
            $display("FAIL realign_next: got es=%b bx=%0d want 1 7",
                     event_start, bxout);
        end
        tick();
        checks++;
        if (dataout_valid !== 1'b0 || late !== 1'b0) begin
            fails++;
            $display("FAIL realign_empty_evt: got v=%b late=%b want 0 0",
                     dataout_valid, late);
        end
    endtask

    initial begin
        bus.eventin = 1'b0;
        bus.bxin = '0;
        bus.numin = '0;
        bus.datain = '0;
        bus.datain_valid = 1'b0;
        test_reset();
        test_overflow();
        test_reset_mid();
        test_single_event();
        test_three_events();
        test_truncate();
        test_stall();
        test_bc0_realign();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/spaceinputs_sched.md
Name: spaceinputs_sched

Overview:
- Test-bench-side scheduler that paces recorded input stubs into the tracklet pipeline at the real event rate.
- Buffers each event's header (bx, stub count) and stub words, then releases exactly one event per EVT_PERIOD-clock slot aligned to BC0.
- Within a slot, words are spaced SPACING clocks apart.
- Sits between the file/pattern source and the first processing stage.

Parameters:
- DATA_W, 36, stub word width
- BX_W, 3, bunch-crossing tag width
- NUM_W, 6, stub-count width
- FIFO_AW, 6, data FIFO address bits (depth 64)
- HDR_AW, 2, header queue address bits (depth 4)
- EVT_PERIOD, 108, clocks per event slot (≥2)
- SPACING, 2, clocks between emitted words (≥1)
- MAXW, 53, max words per event; must be ≤ floor((EVT_PERIOD-1)/SPACING)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- BC0  in  1  orbit marker pulse; arms and re-aligns slot counter
- eventin  in  1  start-of-event strobe, qualifies bxin/numin
- bxin  in  BX_W  bx of new event
- numin  in  NUM_W  declared stub count of new event
- datain  in  DATA_W  stub word
- datain_valid  in  1  datain qualifier
- in_ready  out  1  source may present eventin/datain_valid this cycle
- dataout  out  DATA_W  paced stub word
- dataout_valid  out  1  dataout qualifier
- bxout  out  BX_W  bx of event currently being emitted
- event_start  out  1  one-clock pulse at slot start when an event header is popped
- late  out  1  one-clock pulse: slot boundary reached while previous event still emitting
- truncated  out  1  one-clock pulse: input word dropped (index ≥ MAXW)
- overflow  out  1  sticky: eventin or datain_valid asserted while in_ready=0

Behaviour:
- Reset (reset=0): all outputs 0, FIFOs empty, disarmed, slot counter 0, overflow cleared.
- in_ready = !hdr_full && !data_full (combinational from registered pointers).
- Input side:
  - eventin & in_ready: push {bxin, min(numin, MAXW)}; input word index cleared to 0.
  - datain_valid & in_ready: if index < MAXW, push word and increment index; else drop the word and pulse truncated next clock.
  - Same-cycle eventin + datain_valid: the word is index 0 of the new event.
  - Any strobe with in_ready=0: strobe ignored, overflow set (sticky until reset).
- Slot counter:
  - Disarmed until first BC0.
  - BC0=1 (armed or not): counter←0 and this cycle is a slot start. Otherwise counter increments and wraps EVT_PERIOD-1→0; wrap cycle is a slot start.
- Emit FSM, states IDLE, EMIT, GAP:
  - IDLE, slot start, header queue non-empty: pop header; bxout←bx; remaining←count; event_start=1 next clock. Go EMIT if count>0, else stay IDLE.
  - EMIT: if data FIFO non-empty, pop word; dataout/dataout_valid registered next clock (1-clock pop-to-output latency); remaining−1. Then go IDLE if remaining hits 0, else GAP (SPACING>1) or stay EMIT (SPACING=1). If data FIFO is empty, stall in EMIT with valid=0.
  - GAP: wait SPACING-1 clocks, then EMIT.
  - Slot start while not IDLE: late pulse; current event continues; that slot is skipped (no pop). Next pop at next slot start in IDLE.
  - dataout holds last value when valid=0; bxout holds until next pop.
- Simultaneous push and pop on either queue is allowed at any fill level: full and empty flags are consistent; occupancy is unchanged.

Test Plan:
1. Reset low mid-emission → all outputs 0, in_ready=1, overflow cleared. Release, BC0 at t0, one event (bx=5, num=3, words A,B,C) preloaded → event_start at t0+1, A/B/C valid at t0+2, t0+4, t0+6, bxout=5.
2. Three events of 2 words, BC0 at t0 → event_start at t0+1, t0+109, t0+217; no late.
3. Event num=60 with 60 words supplied → 53 words emitted, truncated pulsed 7 times, no late.
4. Event num=4, only 2 words supplied before slot, rest after 150 clocks → stall; late pulses at next slot start; next event starts one slot later.
5. Preload 4 headers, then eventin with in_ready=0 → overflow=1 and stays set. Same with a full data FIFO (64 words).
6. BC0 re-asserted at counter=40 during IDLE with header pending → pop on BC0 cycle; counter restarts at 0.
